instr_fetch: RTL and testbench

- Initiator side of the instruction-memory read port.
- Owns the word-indexed PC. Drives enable and address into the synchronous-read instruction memory, which has 1-cycle read latency and holds its output when not enabled.
- Captures returned words into a 2-entry buffer and hands {instr, pc} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and out-of-range PC faults.

---
 rtl/fetch_defs_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 64 ++++++
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// default geometry and instruction width.
package fetch_defs;

    localparam int INSTR_W       = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_RESET_PC  = 0;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {instr, pc} FIFO between the memory response and decode.
// The head entry drives the outputs directly; flush empties it in one cycle.
module fetch_skid_buf
    import fetch_defs::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [1:0]         occ_o,
    output logic               head_valid_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [ADDR_W-1:0]  head_pc_o
);

    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                instr_q[wr_ptr_q] <= push_instr_i;
                pc_q[wr_ptr_q]    <= push_pc_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign occ_o        = occ_q;
    assign head_valid_o = (occ_q != 2'd0);
    assign head_instr_o = instr_q[rd_ptr_q];
    assign head_pc_o    = pc_q[rd_ptr_q];

    // The issue rule upstream guarantees neither can happen.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && occ_q == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && !flush_i && occ_q == 2'd0));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the word PC, issues reads to a 1-cycle synchronous
// memory, buffers responses and hands {instr, pc} to decode over valid/ready.
// Optional INSTR_FETCH_PERF_EN adds saturating pop/stall counters.
//
//   state   | meaning
//   S_BOOT  | one idle cycle after reset
//   S_RUN   | issuing requests while PC is in range and buffer has room
//   S_FAULT | PC left memory; no requests, buffer drains, fetch_fault=1
module instr_fetch
    import fetch_defs::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter int                MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_e,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               fetch_fault
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              pend_q, pend_d;
    logic [1:0]        occ;
    logic              hs;
    logic              pop;
    logic              push;
    logic              in_range;
    logic              room;

    assign hs       = instr_valid && instr_ready;
    assign pop      = hs && !redirect_valid;
    assign push     = pend_q && !redirect_valid;
    assign in_range = ({1'b0, pc_q} < DEPTH_X);
    // Compare as occ+pend < 2+hs to avoid an unsigned underflow.
    assign room     = ({1'b0, occ} + {2'b00, pend_q}) < (3'd2 + {2'b00, hs});

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        pend_d   = 1'b0;
        mem_e    = 1'b0;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN: begin
                if (!redirect_valid) begin
                    if (!in_range) begin
                        state_d = S_FAULT;
                    end else if (room) begin
                        mem_e    = 1'b1;
                        pc_d     = pc_q + ADDR_W'(1);
                        pend_d   = 1'b1;
                        req_pc_d = pc_q;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_BOOT;
        endcase
        if (redirect_valid) begin
            state_d = S_RUN;
            pc_d    = redirect_pc;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            pend_q   <= pend_d;
        end
    end

    assign mem_addr    = pc_q;
    assign fetch_fault = (state_q == S_FAULT);

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_instr_i (mem_data),
        .push_pc_i    (req_pc_q),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .occ_o        (occ),
        .head_valid_o (instr_valid),
        .head_instr_o (instr_out),
        .head_pc_o    (instr_pc)
    );

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (instr_valid && !instr_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// reset sequences, against a preloaded 1-cycle synchronous memory model.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        mem_e;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fetch_fault;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_e          (mem_e),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem[i] = 0xA000_0000 + i for the 256 in-range words.
    initial mem_data = 32'h0;
    always @(posedge clk) begin
        if (mem_e) mem_data <= (mem_addr < 32'd256) ? (32'hA000_0000 + mem_addr) : 32'hDEAD_BEEF;
    end

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          me;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        bit          ff;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];
    int   n_vec = 0;
    int   n_bad = 0;
    int   step  = 0;

    function automatic vec_t mk(bit rdy, bit rv, logic [31:0] rpc, bit me,
                                logic [31:0] addr, bit v, logic [31:0] pc, bit ff);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.me = me;
        r.addr = addr; r.v = v; r.pc = pc; r.ff = ff;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // Entered just after a posedge; leaves just after the posedge following hi.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step           = i;
            instr_ready    = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            @(negedge clk);
            chk("mem_e", 32'(mem_e), 32'(vt[i].me));
            if (vt[i].me) chk("mem_addr", mem_addr, vt[i].addr);
            chk("instr_valid", 32'(instr_valid), 32'(vt[i].v));
            if (vt[i].v) begin
                chk("instr_pc", instr_pc, vt[i].pc);
                chk("instr_out", instr_out, 32'hA000_0000 + vt[i].pc);
            end
            chk("fetch_fault", 32'(fetch_fault), 32'(vt[i].ff));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_e"}, 32'(mem_e), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_out"}, instr_out, 32'd0);
        chk({tag, "_pc"}, instr_pc, 32'd0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
        chk({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
    endtask

    initial begin
        int exp_f;
        int exp_s;
        //            rdy rv rpc     me addr    v  pc      ff
        vt[0]  = mk(1, 0, 32'h0,  0, 32'h0,  0, 32'h0,  0);
        vt[1]  = mk(1, 0, 32'h0,  1, 32'h0,  0, 32'h0,  0);
        vt[2]  = mk(1, 0, 32'h0,  1, 32'h1,  0, 32'h0,  0);
        vt[3]  = mk(1, 0, 32'h0,  1, 32'h2,  1, 32'h0,  0);
        vt[4]  = mk(1, 0, 32'h0,  1, 32'h3,  1, 32'h1,  0);
        vt[5]  = mk(1, 0, 32'h0,  1, 32'h4,  1, 32'h2,  0);
        vt[6]  = mk(1, 0, 32'h0,  1, 32'h5,  1, 32'h3,  0);
        vt[7]  = mk(1, 0, 32'h0,  1, 32'h6,  1, 32'h4,  0);
        vt[8]  = mk(0, 0, 32'h0,  0, 32'h7,  1, 32'h5,  0);
        vt[9]  = mk(0, 0, 32'h0,  0, 32'h7,  1, 32'h5,  0);
        vt[10] = mk(0, 0, 32'h0,  0, 32'h7,  1, 32'h5,  0);
        vt[11] = mk(0, 0, 32'h0,  0, 32'h7,  1, 32'h5,  0);
        vt[12] = mk(1, 0, 32'h0,  1, 32'h7,  1, 32'h5,  0);
        vt[13] = mk(1, 0, 32'h0,  1, 32'h8,  1, 32'h6,  0);
        vt[14] = mk(1, 1, 32'h40, 0, 32'h9,  1, 32'h7,  0);
        vt[15] = mk(1, 0, 32'h0,  1, 32'h40, 0, 32'h0,  0);
        vt[16] = mk(1, 0, 32'h0,  1, 32'h41, 0, 32'h0,  0);
        vt[17] = mk(1, 0, 32'h0,  1, 32'h42, 1, 32'h40, 0);
        vt[18] = mk(1, 0, 32'h0,  1, 32'h43, 1, 32'h41, 0);
        vt[19] = mk(1, 1, 32'hFE, 0, 32'h44, 1, 32'h42, 0);
        vt[20] = mk(1, 0, 32'h0,  1, 32'hFE, 0, 32'h0,  0);
        vt[21] = mk(1, 0, 32'h0,  1, 32'hFF, 0, 32'h0,  0);
        vt[22] = mk(1, 0, 32'h0,  0, 32'h100,1, 32'hFE, 0);
        vt[23] = mk(1, 0, 32'h0,  0, 32'h100,1, 32'hFF, 1);
        vt[24] = mk(1, 0, 32'h0,  0, 32'h100,0, 32'h0,  1);
        vt[25] = mk(1, 1, 32'h0,  0, 32'h100,0, 32'h0,  1);
        vt[26] = mk(1, 0, 32'h0,  1, 32'h0,  0, 32'h0,  0);
        vt[27] = mk(1, 0, 32'h0,  1, 32'h1,  0, 32'h0,  0);
        vt[28] = mk(1, 0, 32'h0,  1, 32'h2,  1, 32'h0,  0);

        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vecs(0, 27);

        exp_f = 0;
        exp_s = 0;
        for (int i = 0; i <= 27; i++) begin
            if (vt[i].v && vt[i].rdy && !vt[i].rv) exp_f++;
            if (vt[i].v && !vt[i].rdy) exp_s++;
        end
`ifdef INSTR_FETCH_PERF_EN
        step = 28;
        chk("perf_fetched", perf_fetched, 32'(exp_f));
        chk("perf_stall", perf_stall, 32'(exp_s));
`endif
        run_vecs(28, 28);

        // Mid-stream async reset: a response is pending and the buffer is non-empty.
        step           = 100;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        chk("pre_rst_pending_valid", 32'(instr_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vecs(0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
